terrain_crater_writer: RTL and testbench

- Write-side master for the terrain column memory. The colour mapper and player read that memory; this block writes to it.
- Accepts one explosion request (centre x/y, radius) and performs read-modify-write on every affected 480-bit column, clearing solid bits inside the circle.
- Writes are issued only while the write window (VGA blanking) is open, so display reads are never disturbed.

---
 rtl/terrain_pkg.sv | 24 ++
 rtl/crater_mask_gen.sv | 29 ++
 rtl/terrain_crater_writer.sv | 171 +++++++++++++++++
 tb/tb_terrain_crater_writer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/terrain_pkg.sv
// Shared terrain geometry, column/coordinate types and the crater writer state set.
package terrain_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned COL_H    = 480;
    localparam int unsigned X_W      = 10;
    localparam int unsigned Y_W      = 9;

    typedef logic [COL_H-1:0] column_t;
    typedef logic [X_W-1:0]   xcoord_t;
    typedef logic [Y_W-1:0]   ycoord_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HCALC,
        ST_WAIT_WIN,
        ST_READ,
        ST_WRITE,
        ST_NEXT,
        ST_DONE
    } crater_state_t;

endpackage

// File: rtl/crater_mask_gen.sv
// Combinational vertical clear mask: bits cy-h..cy+h set, clipped to the column.
module crater_mask_gen
    import terrain_pkg::*;
#(
    parameter int unsigned R_W = 5
) (
    input  logic [Y_W-1:0] cy_i,
    input  logic [R_W-1:0] h_i,
    output column_t        mask_o
);

    logic signed [9:0] lo_s;
    logic signed [9:0] hi_s;
    int                lo_i;
    int                hi_i;

    always_comb begin
        // cy <= 479 and h <= 31 keep both ends inside signed 10-bit range
        lo_s = $signed({1'b0, cy_i}) - $signed(10'(h_i));
        hi_s = $signed({1'b0, cy_i}) + $signed(10'(h_i));
        lo_i = lo_s[9] ? 0 : int'(lo_s);
        hi_i = (hi_s > $signed(10'(COL_H - 1))) ? (int'(COL_H) - 1) : int'(hi_s);
        mask_o = '0;
        for (int unsigned i = 0; i < COL_H; i++) begin
            mask_o[i] = (int'(i) >= lo_i) && (int'(i) <= hi_i);
        end
    end

endmodule

// File: rtl/terrain_crater_writer.sv
// Crater write master: per affected column computes the chord half-height, then
// read-modify-writes the terrain column only while the blanking window is open.
module terrain_crater_writer
    import terrain_pkg::*;
#(
    parameter int unsigned R_W = 5
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [X_W-1:0] req_x,
    input  logic [Y_W-1:0] req_y,
    input  logic [R_W-1:0] req_r,
    input  logic           wr_window,
    output logic [X_W-1:0] rd_addr,
    input  column_t        rd_data,
    output logic           wr_en,
    output logic [X_W-1:0] wr_addr,
    output column_t        wr_data,
    output logic           busy,
    output logic           done
);

    localparam int unsigned SQ_W = 2 * R_W;

    crater_state_t  state_q, state_d;
    xcoord_t        cx_q, cx_d;
    ycoord_t        cy_q, cy_d;
    logic [R_W-1:0] r_q, r_d;
    xcoord_t        x_q, x_d;
    xcoord_t        xend_q, xend_d;
    logic [R_W-1:0] h_q, h_d;
    xcoord_t        rd_addr_q, rd_addr_d;

    logic signed [10:0] xlo_s;
    logic signed [10:0] xhi_s;
    xcoord_t            x_start;
    xcoord_t            x_stop;
    xcoord_t            dx;
    logic [SQ_W-1:0]    r_sq;
    logic [SQ_W-1:0]    dx_sq;
    logic [SQ_W-1:0]    h_sq;
    logic [SQ_W-1:0]    t_rem;
    column_t            mask;
    logic               wr_fire;

    crater_mask_gen #(
        .R_W (R_W)
    ) u_mask (
        .cy_i   (cy_q),
        .h_i    (h_q),
        .mask_o (mask)
    );

    always_comb begin
        xlo_s   = $signed({1'b0, cx_q}) - $signed(11'(r_q));
        xhi_s   = $signed({1'b0, cx_q}) + $signed(11'(r_q));
        x_start = xlo_s[10] ? '0 : xlo_s[9:0];
        x_stop  = (xhi_s > $signed(11'(SCREEN_W - 1))) ? X_W'(SCREEN_W - 1) : xhi_s[9:0];
        dx      = (x_q >= cx_q) ? (x_q - cx_q) : (cx_q - x_q);
        r_sq    = SQ_W'(r_q) * SQ_W'(r_q);
        dx_sq   = SQ_W'(dx) * SQ_W'(dx);
        h_sq    = SQ_W'(h_q) * SQ_W'(h_q);
        // dx never exceeds r, so the remainder cannot go negative
        t_rem   = r_sq - dx_sq;
    end

    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        r_d       = r_q;
        x_d       = x_q;
        xend_d    = xend_q;
        h_d       = h_q;
        rd_addr_d = rd_addr_q;
        wr_fire   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cx_d    = req_x;
                    cy_d    = req_y;
                    r_d     = req_r;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if ((cx_q >= X_W'(SCREEN_W)) || (cy_q >= Y_W'(COL_H))) begin
                    state_d = ST_DONE;
                end else begin
                    x_d     = x_start;
                    xend_d  = x_stop;
                    h_d     = r_q;
                    state_d = ST_HCALC;
                end
            end
            ST_HCALC: begin
                // walk h down from r until h*h <= t, i.e. h = floor(sqrt(t))
                if (h_sq > t_rem) begin
                    h_d = h_q - 1'b1;
                end else begin
                    state_d = ST_WAIT_WIN;
                end
            end
            ST_WAIT_WIN: begin
                if (wr_window) begin
                    rd_addr_d = x_q;
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                state_d = wr_window ? ST_WRITE : ST_WAIT_WIN;
            end
            ST_WRITE: begin
                if (wr_window) begin
                    wr_fire = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_WAIT_WIN;
                end
            end
            ST_NEXT: begin
                if (x_q == xend_q) begin
                    state_d = ST_DONE;
                end else begin
                    x_d     = x_q + 1'b1;
                    h_d     = r_q;
                    state_d = ST_HCALC;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cx_q      <= '0;
            cy_q      <= '0;
            r_q       <= '0;
            x_q       <= '0;
            xend_q    <= '0;
            h_q       <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            r_q       <= r_d;
            x_q       <= x_d;
            xend_q    <= xend_d;
            h_q       <= h_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign rd_addr   = rd_addr_q;
    assign wr_en     = wr_fire;
    assign wr_addr   = wr_fire ? x_q : '0;
    assign wr_data   = wr_fire ? (rd_data & ~mask) : '0;

endmodule

// File: tb/tb_terrain_crater_writer.sv
// Directed + randomized bench for terrain_crater_writer against a geometric crater model.
module tb_terrain_crater_writer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic [9:0]   req_x;
    logic [8:0]   req_y;
    logic [4:0]   req_r;
    logic         wr_window;
    logic [9:0]   rd_addr;
    logic [479:0] rd_data;
    logic         wr_en;
    logic [9:0]   wr_addr;
    logic [479:0] wr_data;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [479:0] mem  [640];
    logic [479:0] refm [640];
    logic         fill_en = 1'b0;
    bit           win_rand = 1'b0;

    int           wq_addr[$];
    logic [479:0] wq_data[$];
    int           win_viol = 0;
    int           exp_addr[$];
    logic [479:0] exp_data[$];

    terrain_crater_writer #(.R_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_r     (req_r),
        .wr_window (wr_window),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .done      (done)
    );

    always #10 clk = ~clk;

    // Terrain memory: registered read, synchronous write
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 640; i++) mem[i] <= refm[i];
        end else begin
            if (rd_addr < 10'd640) rd_data <= mem[rd_addr];
            if (wr_en && wr_addr < 10'd640) mem[wr_addr] <= wr_data;
        end
    end

    always @(negedge clk) begin
        if (reset_n && wr_en) begin
            wq_addr.push_back(int'(wr_addr));
            wq_data.push_back(wr_data);
            if (!wr_window) win_viol++;
        end
    end

    initial begin
        wr_window = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            wr_window = win_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [479:0] obs, input logic [479:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Crater reference: clear every cell of each column within the integer chord of the circle
    task automatic model_req(input int cx, input int cy, input int r, input int maxcols,
                             output int lat);
        int x0, x1, dx, t, h, ncol;
        lat  = 2;
        ncol = 0;
        if (cx >= 640 || cy >= 480) return;
        x0 = (cx - r < 0) ? 0 : cx - r;
        x1 = (cx + r > 639) ? 639 : cx + r;
        for (int x = x0; x <= x1 && ncol < maxcols; x++) begin
            dx = (x > cx) ? x - cx : cx - x;
            t  = r * r - dx * dx;
            h  = 0;
            while ((h + 1) * (h + 1) <= t) h++;
            for (int y = cy - h; y <= cy + h; y++)
                if (y >= 0 && y < 480) refm[x][y] = 1'b0;
            exp_addr.push_back(x);
            exp_data.push_back(refm[x]);
            lat += r - h + 5;
            ncol++;
        end
    endtask

    task automatic fill(input bit ones);
        for (int i = 0; i < 640; i++) begin
            if (ones) refm[i] = '1;
            else for (int w = 0; w < 15; w++) refm[i][w*32 +: 32] = $urandom;
        end
        @(negedge clk); fill_en = 1'b1;
        @(negedge clk); fill_en = 1'b0;
    endtask

    task automatic send(input int x, input int y, input int r);
        int n;
        @(negedge clk);
        req_x = 10'(x); req_y = 9'(y); req_r = 5'(r); req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        chk("ready_seen", req_ready, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_after_accept", {busy, req_ready}, 2'b10);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 6000) begin @(negedge clk); cyc++; end
        chk("done_seen", done, 1'b1);
    endtask

    task automatic post_idle();
        @(negedge clk);
        chk("idle_after_done", {req_ready, busy, done}, 3'b100);
    endtask

    task automatic check_writes(input int eb, input int wb);
        int ne, nw;
        ne = exp_addr.size() - eb;
        nw = wq_addr.size() - wb;
        chk("wr_count", nw, ne);
        for (int i = 0; i < ne && i < nw; i++) begin
            chk("wr_addr", wq_addr[wb+i], exp_addr[eb+i]);
            chk("wr_data", wq_data[wb+i], exp_data[eb+i]);
        end
    endtask

    task automatic check_mem();
        int bad, first;
        bad = 0; first = -1;
        for (int i = 0; i < 640; i++)
            if (mem[i] !== refm[i]) begin bad++; if (first < 0) first = i; end
        chk("mem_columns_bad", bad, 0);
        if (first >= 0) chk("mem_first_bad_col", mem[first], refm[first]);
    endtask

    task automatic run_req(input int x, input int y, input int r, input bit chklat);
        int eb, wb, lat, cyc;
        eb = exp_addr.size();
        wb = wq_addr.size();
        model_req(x, y, r, 1000, lat);
        send(x, y, r);
        wait_done(cyc);
        if (chklat) chk("latency", cyc, lat);
        post_idle();
        check_writes(eb, wb);
        check_mem();
    endtask

    initial begin
        int eb, wb, lat, cyc, bad, n, cx, cy;
        reset_n = 1'b0; req_valid = 1'b0;
        req_x = '0; req_y = '0; req_r = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {req_ready, busy, done, wr_en}, 4'b1000);
        chk("reset_addr", {rd_addr, wr_addr}, 20'd0);
        chk("reset_wdata", wr_data, '0);
        reset_n = 1'b1;

        fill(1'b1);
        run_req(100, 200, 0, 1'b1);
        fill(1'b1);
        run_req(0, 200, 3, 1'b1);
        fill(1'b1);
        run_req(320, 478, 4, 1'b1);
        run_req(639, 5, 6, 1'b1);
        run_req(700, 10, 5, 1'b1);
        run_req(50, 480, 7, 1'b1);

        // Second request held while busy is only taken after done
        fill(1'b0);
        eb = exp_addr.size(); wb = wq_addr.size();
        model_req(200, 100, 5, 1000, lat);
        model_req(210, 300, 2, 1000, lat);
        send(200, 100, 5);
        req_x = 10'd210; req_y = 9'd300; req_r = 5'd2; req_valid = 1'b1;
        bad = 0; cyc = 1;
        while (!done && cyc < 6000) begin @(negedge clk); cyc++; if (req_ready) bad++; end
        chk("busy_done_seen", done, 1'b1);
        chk("ready_while_busy", bad, 0);
        @(negedge clk);
        chk("ready_after_done", req_ready, 1'b1);
        @(negedge clk);
        chk("queued_accepted", {busy, req_ready}, 2'b10);
        req_valid = 1'b0;
        wait_done(cyc);
        post_idle();
        check_writes(eb, wb);
        check_mem();

        // Open-window random craters with latency checking
        for (int k = 0; k < 10; k++) begin
            cx = ($urandom_range(0, 9) == 0) ? $urandom_range(640, 1023) : $urandom_range(0, 639);
            cy = ($urandom_range(0, 9) == 0) ? $urandom_range(480, 511) : $urandom_range(0, 479);
            run_req(cx, cy, $urandom_range(0, 31), 1'b1);
        end

        // Flickering write window: stalls in READ/WRITE must not change the result
        win_rand = 1'b1;
        fill(1'b0);
        run_req(0, 200, 3, 1'b0);
        for (int k = 0; k < 6; k++)
            run_req($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 31), 1'b0);
        win_rand = 1'b0;

        // Reset during HCALC of the second column abandons the request
        fill(1'b1);
        eb = exp_addr.size(); wb = wq_addr.size();
        model_req(4, 100, 3, 1, lat);
        send(4, 100, 3);
        n = 0;
        while (!wr_en && n < 200) begin @(negedge clk); n++; end
        chk("first_write_seen", wr_en, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {req_ready, busy, done, wr_en}, 4'b1000);
        chk("rst_mid_rdaddr", rd_addr, 10'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_mid_idle", {req_ready, busy, done}, 3'b100);
        check_writes(eb, wb);
        check_mem();

        chk("wr_outside_window", win_viol, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
